// File: rtl/sa_requester.sv
// Adder requester: drives one operand pair into an external adder, waits for its
// result (or a timeout), and reports pass/fail against the locally computed sum.
module sa_requester #(
  parameter int BUS_WIDTH = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BUS_WIDTH-1:0] req_a,
  input  logic [BUS_WIDTH-1:0] req_b,
  output logic [BUS_WIDTH-1:0] sig_ina,
  output logic [BUS_WIDTH-1:0] sig_inb,
  output logic                 sig_en_i,
  input  logic [BUS_WIDTH-1:0] sig_out,
  input  logic                 sig_en_o,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_sum,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [15:0]          pass_cnt,
  output logic [15:0]          fail_cnt,
  output logic                 spurious
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, REPORT} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t               state, state_next;
  logic [BUS_WIDTH-1:0] op_a, op_b, expected;
  logic [7:0]           timer;
  logic                 accept, got_rsp, timed_out, rsp_fire, stray_rsp;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign got_rsp   = sig_en_o && ((state == DRIVE) || (state == WAIT));
  assign timed_out = (state == WAIT) && !sig_en_o && (timer == TIMER_LAST);
  assign rsp_fire  = (state == REPORT) && rsp_ready;
  assign stray_rsp = sig_en_o && ((state == IDLE) || (state == REPORT));
  assign expected  = op_a + op_b;

  assign rsp_valid = (state == REPORT);
  assign sig_en_i  = (state == DRIVE);
  assign sig_ina   = sig_en_i ? op_a : '0;
  assign sig_inb   = sig_en_i ? op_b : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   state_next = sig_en_o ? REPORT : WAIT;
      WAIT:    if (got_rsp || timed_out) state_next = REPORT;
      REPORT:  if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Report fields only change on the DRIVE/WAIT -> REPORT transition, so they stay stable under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      timer       <= '0;
      rsp_sum     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      spurious    <= 1'b0;
    end else begin
      if (accept) begin
        op_a <= req_a;
        op_b <= req_b;
      end
      if (state == DRIVE)
        timer <= '0;
      else if ((state == WAIT) && !sig_en_o && !timed_out)
        timer <= timer + 8'd1;
      if (got_rsp) begin
        rsp_sum     <= sig_out;
        rsp_timeout <= 1'b0;
        rsp_err     <= (sig_out != expected);
      end else if (timed_out) begin
        rsp_sum     <= '0;
        rsp_timeout <= 1'b1;
        rsp_err     <= 1'b1;
      end
      if (stray_rsp)
        spurious <= 1'b1;
      if (rsp_fire) begin
        if (rsp_err) begin
          if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
        end else begin
          if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_requester.sv
// Directed bench for sa_requester: the bench plays the adder and checks each
// report, counter and strobe against hand-computed values.
module tb_sa_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [3:0]  req_a, req_b, sig_ina, sig_inb, sig_out, rsp_sum;
  logic        sig_en_i, sig_en_o, rsp_valid, rsp_ready, rsp_err, rsp_timeout, spurious;
  logic [15:0] pass_cnt, fail_cnt;

  int checks = 0;
  int passes = 0;

  logic       drv_en;
  logic [3:0] drv_a, drv_b;
  int         lat_seen;

  sa_requester #(.BUS_WIDTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .sig_ina(sig_ina), .sig_inb(sig_inb), .sig_en_i(sig_en_i),
    .sig_out(sig_out), .sig_en_o(sig_en_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .spurious(spurious)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge, away from the active edge
  task automatic tick();
    @(negedge clk);
  endtask

  // Issue one request and act as the adder: respond `lat` cycles after sig_en_i (lat<0: never).
  // Returns with the DUT in REPORT (rsp_ready low) and lat_seen = cycles from DRIVE to rsp_valid.
  task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input int lat, input logic [3:0] out);
    tick();
    req_valid = 1'b1; req_a = a; req_b = b; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    drv_en = sig_en_i; drv_a = sig_ina; drv_b = sig_inb;
    if (lat == 0) begin sig_en_o = 1'b1; sig_out = out; end
    lat_seen = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      sig_en_o = 1'b0; sig_out = 4'h0;
      if (rsp_valid) begin lat_seen = cyc; break; end
      if (cyc == lat) begin sig_en_o = 1'b1; sig_out = out; end
    end
  endtask

  task automatic accept_report();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    sig_out = '0; sig_en_o = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    checks++; if (req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready got=%b want=0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid got=%b want=0", rsp_valid); else passes++;
    checks++; if (sig_en_i !== 1'b0) $display("[TB] FAIL reset_sig_en_i got=%b want=0", sig_en_i); else passes++;
    checks++; if (spurious !== 1'b0) $display("[TB] FAIL reset_spurious got=%b want=0", spurious); else passes++;
    checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0)
      $display("[TB] FAIL reset_counters got=%0d/%0d want=0/0", pass_cnt, fail_cnt); else passes++;
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL idle_req_ready got=%b want=1", req_ready); else passes++;
  endtask

  task automatic test_basic();
    run_txn(4'd3, 4'd5, 2, 4'd8);
    checks++; if (drv_en !== 1'b1 || drv_a !== 4'd3 || drv_b !== 4'd5)
      $display("[TB] FAIL basic_drive got=%b/%0d/%0d want=1/3/5", drv_en, drv_a, drv_b); else passes++;
    checks++; if (lat_seen !== 3) $display("[TB] FAIL basic_latency got=%0d want=3", lat_seen); else passes++;
    checks++; if (rsp_sum !== 4'd8 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
      $display("[TB] FAIL basic_report got=%0d/%b/%b want=8/0/0", rsp_sum, rsp_err, rsp_timeout); else passes++;
    accept_report();
    checks++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0)
      $display("[TB] FAIL basic_counters got=%0d/%0d want=1/0", pass_cnt, fail_cnt); else passes++;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      $display("[TB] FAIL basic_back_to_idle got=%b/%b want=1/0", req_ready, rsp_valid); else passes++;
    checks++; if (sig_en_i !== 1'b0 || sig_ina !== 4'd0 || sig_inb !== 4'd0)
      $display("[TB] FAIL idle_sig_zero got=%b/%0d/%0d want=0/0/0", sig_en_i, sig_ina, sig_inb); else passes++;
  endtask

  task automatic test_wrap();
    run_txn(4'd9, 4'd9, 1, 4'd2);
    checks++; if (rsp_sum !== 4'd2 || rsp_err !== 1'b0)
      $display("[TB] FAIL wrap_pass got=%0d/%b want=2/0", rsp_sum, rsp_err); else passes++;
    accept_report();
    checks++; if (pass_cnt !== 16'd2) $display("[TB] FAIL wrap_pass_cnt got=%0d want=2", pass_cnt); else passes++;
    run_txn(4'd9, 4'd9, 1, 4'd3);
    checks++; if (rsp_sum !== 4'd3 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0)
      $display("[TB] FAIL wrap_mismatch got=%0d/%b/%b want=3/1/0", rsp_sum, rsp_err, rsp_timeout); else passes++;
    accept_report();
    checks++; if (fail_cnt !== 16'd1 || pass_cnt !== 16'd2)
      $display("[TB] FAIL wrap_counters got=%0d/%0d want=2/1", pass_cnt, fail_cnt); else passes++;
  endtask

  task automatic test_timeout();
    run_txn(4'd1, 4'd1, -1, 4'd0);
    checks++; if (lat_seen !== 9) $display("[TB] FAIL timeout_latency got=%0d want=9", lat_seen); else passes++;
    checks++; if (rsp_timeout !== 1'b1 || rsp_err !== 1'b1 || rsp_sum !== 4'd0)
      $display("[TB] FAIL timeout_report got=%b/%b/%0d want=1/1/0", rsp_timeout, rsp_err, rsp_sum); else passes++;
    accept_report();
    checks++; if (fail_cnt !== 16'd2) $display("[TB] FAIL timeout_fail_cnt got=%0d want=2", fail_cnt); else passes++;
  endtask

  task automatic test_zero_latency();
    run_txn(4'd4, 4'd3, 0, 4'd7);
    checks++; if (lat_seen !== 1) $display("[TB] FAIL zerolat_latency got=%0d want=1", lat_seen); else passes++;
    checks++; if (rsp_sum !== 4'd7 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
      $display("[TB] FAIL zerolat_report got=%0d/%b/%b want=7/0/0", rsp_sum, rsp_err, rsp_timeout); else passes++;
    accept_report();
    checks++; if (pass_cnt !== 16'd3) $display("[TB] FAIL zerolat_pass_cnt got=%0d want=3", pass_cnt); else passes++;
  endtask

  task automatic test_backpressure();
    run_txn(4'd3, 4'd5, 2, 4'd8);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 4'd8 || rsp_err !== 1'b0 || req_ready !== 1'b0 || pass_cnt !== 16'd3)
        $display("[TB] FAIL hold_%0d got=v%b s%0d e%b r%b p%0d want=v1 s8 e0 r0 p3",
                 i, rsp_valid, rsp_sum, rsp_err, req_ready, pass_cnt); else passes++;
      if (i == 2) begin sig_en_o = 1'b1; sig_out = 4'hF; end
      tick();
      sig_en_o = 1'b0; sig_out = 4'h0;
    end
    checks++; if (spurious !== 1'b1 || rsp_sum !== 4'd8)
      $display("[TB] FAIL report_stray_rsp got=%b/%0d want=1/8", spurious, rsp_sum); else passes++;
    accept_report();
    checks++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd2)
      $display("[TB] FAIL hold_counters got=%0d/%0d want=4/2", pass_cnt, fail_cnt); else passes++;
  endtask

  task automatic test_reset_mid();
    tick();
    req_valid = 1'b1; req_a = 4'd2; req_b = 4'd2;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || spurious !== 1'b0)
      $display("[TB] FAIL midrst_state got=%b/%b/%b want=0/0/0", req_ready, rsp_valid, spurious); else passes++;
    rst = 1'b0;
    tick();
    sig_en_o = 1'b1; sig_out = 4'd4;
    tick();
    sig_en_o = 1'b0; sig_out = 4'd0;
    tick();
    checks++; if (rsp_valid !== 1'b0 || pass_cnt !== 16'd0 || fail_cnt !== 16'd0)
      $display("[TB] FAIL midrst_no_report got=%b/%0d/%0d want=0/0/0", rsp_valid, pass_cnt, fail_cnt); else passes++;
    checks++; if (spurious !== 1'b1) $display("[TB] FAIL idle_spurious got=%b want=1", spurious); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL midrst_ready got=%b want=1", req_ready); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_zero_latency();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
